// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Multi-channel automatic clock-gating controller.
// Each channel runs an idle-timeout FSM (RUN/OFF/WAKE) and drives one gated
// clock through a latch+AND cell. Auto-gating happens after IDLE_CYCLES
// consecutive idle samples, and the channel wakes on busy_i.
// Ports:
//   clk_i       free-running root clock
//   rst_ni      asynchronous active-low reset
//   test_en_i   scan/test mode, forces every clk_o[i] to follow clk_i
//   busy_i      per-channel activity/request
//   force_on_i  per-channel override, holds the channel in RUN
//   clk_o       gated clocks
//   ready_o     channel in RUN
//   gated_o     channel in OFF
//   idle_cnt_o  per-channel counter, CNT_W bits per channel
module cv32e40p_clock_gate_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter bit          RESET_ON    = 1'b1,
  localparam int unsigned CNT_MAX    = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES,
  localparam int unsigned CNT_W      = ($clog2(CNT_MAX + 1) < 1) ? 1 : $clog2(CNT_MAX + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_en_i,
  input  logic [NUM_CH-1:0]       busy_i,
  input  logic [NUM_CH-1:0]       force_on_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       ready_o,
  output logic [NUM_CH-1:0]       gated_o,
  output logic [NUM_CH*CNT_W-1:0] idle_cnt_o
);

  // State encoding chosen so ready_o/gated_o are single register bits.
  localparam logic [1:0] S_WAKE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_OFF  = 2'b10;
  localparam logic [1:0] S_RST  = RESET_ON ? S_RUN : S_OFF;

  localparam int unsigned IDLE_LAST = (IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1;
  localparam int unsigned WAKE_LAST = (WAKE_CYCLES == 0) ? 0 : WAKE_CYCLES - 1;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_en;
    logic             r_latch;

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_state <= S_RST;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // Next-state logic; force_on overrides everything.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (force_on_i[g]) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (IDLE_CYCLES == 0 || busy_i[g]) begin
              w_cnt_nxt = '0;
            end else if (r_cnt == CNT_W'(IDLE_LAST)) begin
              w_state_nxt = S_OFF;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          S_OFF: begin
            if (busy_i[g]) begin
              w_state_nxt = S_WAKE;
              w_cnt_nxt   = '0;
            end
          end
          S_WAKE: begin
            // busy_i is deliberately ignored: a started wake always completes.
            if (r_cnt == CNT_W'(WAKE_LAST)) begin
              w_state_nxt = S_RUN;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
          default: begin
            w_state_nxt = S_RST;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end

    assign w_en = (r_state != S_OFF) | force_on_i[g];

    // Gate latch only opens in the low phase, so reset can never truncate or
    // create a high pulse; during reset it loads the reset-state enable.
    always_latch begin
      if (!clk_i) begin
        r_latch <= rst_ni ? (w_en | test_en_i) : (RESET_ON | test_en_i);
      end
    end

    assign clk_o[g]                  = clk_i & r_latch;
    assign ready_o[g]                = r_state[0];
    assign gated_o[g]                = r_state[1];
    assign idle_cnt_o[g*CNT_W +: CNT_W] = r_cnt;
  end

endmodule

// File: doc/cv32e40p_clock_gate_ctrl.md
Name: cv32e40p_clock_gate_ctrl

Overview:
- Multi-channel automatic clock-gating controller.
- Each channel owns an idle-timeout FSM and a latch+AND glitch-free clock gate driving one gated clock domain (e.g. FPU, multiplier, debug unit).
- A channel gates its clock after a programmable run of idle cycles and re-enables it on demand, with a fixed wake-up delay before it reports ready.
- Sits between the core clock root and the optional sub-units.

Parameters:
NUM_CH, 4, number of independent gated-clock channels (1..32)
IDLE_CYCLES, 16, consecutive idle samples before gating; 0 disables auto-gating (channel never leaves RUN)
WAKE_CYCLES, 2, cycles spent in WAKE before ready (>=1)
RESET_ON, 1, 1: channels leave reset in RUN; 0: channels leave reset in OFF

Ports:
clk_i  input  1  free-running root clock
rst_ni  input  1  asynchronous active-low reset
test_en_i  input  1  scan/test mode; forces every clk_o[i] to follow clk_i
busy_i  input  NUM_CH  per-channel activity/request, sampled on rising clk_i
force_on_i  input  NUM_CH  per-channel software override; holds channel in RUN
clk_o  output  NUM_CH  gated clocks
ready_o  output  NUM_CH  channel clock running and stable (state RUN)
gated_o  output  NUM_CH  channel in OFF
idle_cnt_o  output  NUM_CH*CNT_W  per-channel idle counter; CNT_W = max(1, clog2(max(IDLE_CYCLES, WAKE_CYCLES)+1))

Behaviour:
- One FSM per channel, states RUN, OFF, WAKE, plus one counter cnt[CNT_W] per channel. All registers are on the rising clk_i edge with asynchronous clear on rst_ni low.
- Reset:
  - RESET_ON=1: state=RUN, cnt=0, ready_o=1, gated_o=0.
  - RESET_ON=0: state=OFF, cnt=0, ready_o=0, gated_o=1.
  - Gate latches are cleared to the enable value of the reset state.
- RUN:
  - busy_i[i]=1 -> cnt=0.
  - busy_i[i]=0 and cnt==IDLE_CYCLES-1 -> OFF, cnt=0.
  - Otherwise cnt++.
  - Net effect: OFF is entered on the edge that samples the IDLE_CYCLES-th consecutive idle cycle. With IDLE_CYCLES=0, cnt stays 0 and the channel stays in RUN.
- OFF: busy_i[i]=1 -> WAKE, cnt=0. Otherwise hold.
- WAKE:
  - Gate enabled; cnt++.
  - cnt==WAKE_CYCLES-1 -> RUN, cnt=0.
  - busy_i is ignored in WAKE. A drop of busy_i does not abort the wake.
- force_on_i[i]=1 (highest priority): next state RUN, cnt=0, including from OFF and WAKE. Release resumes normal RUN counting from 0.
- Gate enable en[i] = (state!=OFF) | force_on_i[i]. It is derived from registers and the force input only, never from busy_i directly.
- Gate: latch transparent while clk_i low, capturing en[i]|test_en_i; clk_o[i] = clk_i & latch[i]. No glitches or truncated high phases.
- Latency:
  - Entering OFF at edge N suppresses the clk_o pulse at edge N+1.
  - busy_i sampled at edge N in OFF gives WAKE at N, and a clk_o pulse at N+1.
  - ready_o rises at edge N+WAKE_CYCLES.
- test_en_i: affects the gate only. FSMs, counters, ready_o and gated_o keep operating normally.
- Outputs ready_o, gated_o and idle_cnt_o are direct register decodes with no combinational path from inputs.
- Reset asserted mid-operation (any state, counter value or clock phase) returns to reset values immediately.
- Channels are fully independent. Simultaneous events on different channels never interact.

Test Plan:
1. Reset with RESET_ON=1, NUM_CH=4, busy_i=4'hF -> ready_o=4'hF, gated_o=0, clk_o toggles on all channels, idle_cnt_o=0.
2. IDLE_CYCLES=16, ch0 busy_i dropped at edge 10 -> gated_o[0] rises at edge 25, clk_o[0] flat from edge 26; ch1..3 unaffected.
3. Ch0 in OFF, busy_i[0] pulsed for 1 cycle at edge 40, WAKE_CYCLES=2 -> clk_o[0] pulses from edge 41, ready_o[0] rises at edge 42, then counts idle again and re-gates 16 samples later.
4. Busy glitch: ch2 idle for 15 samples, busy_i[2]=1 for one sample, idle again -> no gating until 16 further idle samples; idle_cnt_o[2] returns to 0 at the glitch.
5. force_on_i[1]=1 while ch1 in WAKE (cnt=0) -> RUN next edge, ready_o[1]=1. With force held and busy low for 100 cycles -> never gated.
6. test_en_i=1 with all channels OFF -> all clk_o follow clk_i, gated_o stays 4'hF. rst_ni pulsed low mid-high-phase -> outputs return to reset values asynchronously, no clk_o glitch.
